bf_dot_feeder: RTL and testbench

Front-end sequencer that drives a bfloat16 MAC as its operand producer and result consumer. It accepts a stream of bf16 operand pairs over a valid/ready handshake and buffers them in a small FIFO. For each job (pairs up to and including the one tagged `s_last`) it clears the accumulator, issues one `mac_en` per pair, captures the settled accumulator and returns the dot product on a valid/ready output port.

---
 rtl/bf_pkg.sv | 25 ++
 rtl/bf_op_fifo.sv | 62 ++++++
 rtl/bf_dot_feeder.sv | 130 +++++++++++++
 tb/tb_bf_dot_feeder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared types and constants for the bf16 dot-product feeder.
// Holds the FSM state encoding and the layout of one buffered operand pair.
package bf_pkg;

    localparam int          BF16_W    = 16;
    localparam logic [15:0] BF16_ONE  = 16'h3F80;
    localparam logic [15:0] BF16_ZERO = 16'h0000;

    // One FIFO entry: {a, b, last}
    localparam int OP_W = 2 * BF16_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SETTLE,
        OUT
    } state_t;

    typedef struct packed {
        logic [BF16_W-1:0] a;
        logic [BF16_W-1:0] b;
        logic              last;
    } op_entry_t;

endpackage

// File: rtl/bf_op_fifo.sv
// Synchronous operand FIFO with a first-word-fall-through head.
// Pointers carry one extra wrap bit so that full and empty are unambiguous.
module bf_op_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          push_ok;
    logic          pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Requests against a full or empty FIFO are ignored rather than corrupting pointers.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/bf_dot_feeder.sv
// Operand sequencer for an external bf16 MAC: buffers pairs, runs one job per
// s_last-terminated group, and returns the settled accumulator with a pair count.
module bf_dot_feeder
    import bf_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    // Both ports: a transfer happens in any cycle where valid && ready at the rising edge;
    // once valid is raised its payload stays stable until ready is seen.
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [BF16_W-1:0] s_a,
    input  logic [BF16_W-1:0] s_b,
    input  logic              s_last,
    output logic [BF16_W-1:0] mac_in_1,
    output logic [BF16_W-1:0] mac_in_2,
    output logic              mac_en,
    output logic              mac_clr,
    input  logic [BF16_W-1:0] mac_acc,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [BF16_W-1:0] m_result,
    output logic [CNT_W-1:0]  m_count,
    output state_t            dbg_state_o
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BF16_W-1:0] result_q, result_d;
    logic [CNT_W-1:0]  count_q, count_d;

    op_entry_t         wr_entry;
    op_entry_t         head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;

    assign wr_entry  = '{a: s_a, b: s_b, last: s_last};
    assign s_ready   = !fifo_full;
    assign fifo_push = s_valid && s_ready;

    bf_op_fifo #(
        .DEPTH (DEPTH),
        .W     (OP_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i (wr_entry),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // The MAC sees the head even when not strobed; zero keeps its inputs quiet when empty.
    assign mac_in_1 = fifo_empty ? BF16_ZERO : head.a;
    assign mac_in_2 = fifo_empty ? BF16_ZERO : head.b;

    assign m_valid     = (state_q == OUT);
    assign m_result    = result_q;
    assign m_count     = count_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        count_d  = count_q;
        mac_clr  = 1'b0;
        mac_en   = 1'b0;
        fifo_pop = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    mac_clr = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // An empty FIFO here is a bubble: hold everything and keep waiting.
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    mac_en   = 1'b1;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (head.last) begin
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                // The MAC registers the final product one cycle after its strobe.
                result_d = mac_acc;
                count_d  = cnt_q;
                state_d  = OUT;
            end
            OUT: begin
                if (m_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= BF16_ZERO;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_bf_dot_feeder.sv
// Bench for bf_dot_feeder: two instances (CNT_W=8 and CNT_W=2) share stimulus,
// each driving its own integer-exact bf16 MAC model.
module tb_bf_dot_feeder;
    import bf_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic [15:0] s_a;
    logic [15:0] s_b;
    logic        s_last;
    logic        m_ready;

    logic        s_ready,   s_ready_s;
    logic [15:0] mac_in_1,  mac_in_1_s;
    logic [15:0] mac_in_2,  mac_in_2_s;
    logic        mac_en,    mac_en_s;
    logic        mac_clr,   mac_clr_s;
    logic [15:0] mac_acc,   mac_acc_s;
    logic        m_valid,   m_valid_s;
    logic [15:0] m_result,  m_result_s;
    logic [7:0]  m_count;
    logic [1:0]  m_count_s;
    state_t      dbg_m,     dbg_s;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_m    = 0;
    int acc_s    = 0;
    int clr_q[$];
    int en_q[$];
    logic both_seen = 1'b0;
    logic [25:0] exp_q[$];

    bf_dot_feeder #(.DEPTH(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_a(s_a), .s_b(s_b), .s_last(s_last),
        .mac_in_1(mac_in_1), .mac_in_2(mac_in_2), .mac_en(mac_en), .mac_clr(mac_clr),
        .mac_acc(mac_acc), .m_valid(m_valid), .m_ready(m_ready),
        .m_result(m_result), .m_count(m_count), .dbg_state_o(dbg_m)
    );

    bf_dot_feeder #(.DEPTH(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_s),
        .s_a(s_a), .s_b(s_b), .s_last(s_last),
        .mac_in_1(mac_in_1_s), .mac_in_2(mac_in_2_s), .mac_en(mac_en_s), .mac_clr(mac_clr_s),
        .mac_acc(mac_acc_s), .m_valid(m_valid_s), .m_ready(m_ready),
        .m_result(m_result_s), .m_count(m_count_s), .dbg_state_o(dbg_s)
    );

    // Exact for non-negative integers 0..255, which is all the bench uses.
    function automatic logic [15:0] bf_enc(input int v);
        int e;
        logic [7:0] ex;
        logic [7:0] m;
        if (v <= 0) return 16'h0000;
        e = 0;
        for (int i = 0; i < 8; i++) if (v >= (1 << i)) e = i;
        ex = 8'(127 + e);
        m  = 8'((v << (7 - e)) & 'h7F);
        return {1'b0, ex, m[6:0]};
    endfunction

    function automatic int bf_dec(input logic [15:0] x);
        int e;
        if (x[14:0] == 15'd0) return 0;
        e = int'(x[14:7]) - 127;
        return int'({1'b1, x[6:0]}) >> (7 - e);
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // MAC models: clear is synchronous, accumulate lands one cycle after mac_en.
    always @(posedge clk) begin
        if (mac_clr) acc_m <= 0;
        else if (mac_en) acc_m <= acc_m + bf_dec(mac_in_1) * bf_dec(mac_in_2);
        if (mac_clr_s) acc_s <= 0;
        else if (mac_en_s) acc_s <= acc_s + bf_dec(mac_in_1_s) * bf_dec(mac_in_2_s);
    end
    assign mac_acc   = bf_enc(acc_m);
    assign mac_acc_s = bf_enc(acc_s);

    always @(negedge clk) begin
        if (mac_clr) clr_q.push_back(cyc);
        if (mac_en) en_q.push_back(cyc);
        if ((mac_en && mac_clr) || (mac_en_s && mac_clr_s)) both_seen = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [15:0] a, input logic [15:0] b, input logic last);
        int bud = 200;
        s_valid = 1'b1; s_a = a; s_b = b; s_last = last;
        while (!s_ready && bud > 0) begin
            step();
            bud--;
        end
        if (bud == 0) chk("push_timeout", s_ready, 1);
        step();
        s_valid = 1'b0; s_a = 16'h0; s_b = 16'h0; s_last = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [15:0] er, input int ec,
                               input int ecs, input int rdly, output int vcyc);
        int bud = 300;
        while (!m_valid && bud > 0) begin
            step();
            bud--;
        end
        chk({tag, "_valid"}, m_valid, 1);
        vcyc = cyc;
        chk({tag, "_result"}, m_result, er);
        chk({tag, "_count"}, m_count, ec);
        chk({tag, "_result_sat"}, m_result_s, er);
        chk({tag, "_count_sat"}, m_count_s, ecs);
        for (int k = 0; k < rdly; k++) begin
            step();
            chk({tag, "_hold"}, {m_valid, m_result}, {1'b1, er});
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask

    initial begin
        int t0, v, cb, eb, n, sum, x, y, hb;
        logic [25:0] e;

        rst_n = 1'b0; s_valid = 1'b0; s_a = 16'h0; s_b = 16'h0; s_last = 1'b0; m_ready = 1'b0;
        step(); step(); step();
        rst_n = 1'b1;
        step();
        chk("rst_s_ready", s_ready, 1);
        chk("rst_mac_en", mac_en, 0);
        chk("rst_mac_clr", mac_clr, 0);
        chk("rst_mac_in", {mac_in_1, mac_in_2}, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_result", m_result, 0);
        chk("rst_m_count", {m_count, m_count_s}, 0);
        chk("rst_state", 32'(dbg_m), 32'(IDLE));

        // Single pair: clr +1, en +2, valid +4
        cb = clr_q.size(); eb = en_q.size(); t0 = cyc;
        push_pair(16'h3F80, 16'h3F80, 1'b1);
        wait_result("single", 16'h3F80, 1, 1, 0, v);
        chk("single_valid_cyc", v - t0, 4);
        chk("single_clr_cyc", (clr_q.size() > cb) ? clr_q[cb] - t0 : -1, 1);
        chk("single_en_n", en_q.size() - eb, 1);
        chk("single_en_cyc", (en_q.size() > eb) ? en_q[eb] - t0 : -1, 2);

        // Two pairs back to back: 1*1 + 2*3 = 7
        cb = clr_q.size(); eb = en_q.size(); t0 = cyc;
        push_pair(16'h3F80, 16'h3F80, 1'b0);
        push_pair(16'h4000, 16'h4040, 1'b1);
        wait_result("two", 16'h40E0, 2, 2, 1, v);
        chk("two_valid_cyc", v - t0, 5);
        chk("two_en_n", en_q.size() - eb, 2);
        chk("two_en_cyc", (en_q.size() > eb + 1) ? {en_q[eb] - t0, en_q[eb+1] - t0} : -1, {32'd2, 32'd3});

        // Bubble: second pair pushed in cycle 4, so it pops in 5 and m_valid lands in 7
        cb = clr_q.size(); eb = en_q.size(); t0 = cyc;
        push_pair(16'h3F80, 16'h3F80, 1'b0);
        step(); step(); step();
        push_pair(16'h4000, 16'h4040, 1'b1);
        wait_result("bubble", 16'h40E0, 2, 2, 0, v);
        chk("bubble_valid_cyc", v - t0, 7);
        chk("bubble_en_n", en_q.size() - eb, 2);
        chk("bubble_en_cyc", (en_q.size() > eb + 1) ? {en_q[eb] - t0, en_q[eb+1] - t0} : -1, {32'd2, 32'd5});
        chk("bubble_clr_cyc", (clr_q.size() > cb) ? clr_q[cb] - t0 : -1, 1);

        // Saturation: five 1.0*1.0 pairs
        for (int i = 0; i < 5; i++) push_pair(16'h3F80, 16'h3F80, i == 4);
        wait_result("sat", 16'h40A0, 5, 3, 2, v);

        // Reset in the middle of a job
        for (int i = 0; i < 3; i++) push_pair(16'h3F80, 16'h3F80, i == 2);
        chk("midrst_pre_en", mac_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_s_ready", s_ready, 1);
        chk("midrst_mac", {mac_en, mac_clr, mac_in_1, mac_in_2}, 0);
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_m_result", m_result, 0);
        chk("midrst_m_count", m_count, 0);
        chk("midrst_state", 32'(dbg_m), 32'(IDLE));
        step();
        rst_n = 1'b1;
        step();
        t0 = cyc;
        push_pair(16'h3F80, 16'h4000, 1'b1);
        wait_result("post_rst", 16'h4000, 1, 1, 0, v);
        chk("post_rst_valid_cyc", v - t0, 4);

        // Backpressure: hold m_ready low while nine pairs arrive at a depth-8 FIFO
        push_pair(16'h3F80, 16'h3F80, 1'b1);
        for (int k = 0; k < 20 && !m_valid; k++) step();
        chk("bp_a_valid", m_valid, 1);
        eb = en_q.size();
        for (int i = 0; i < 9; i++) begin
            s_valid = 1'b1; s_a = 16'h3F80; s_b = 16'h3F80; s_last = (i == 8);
            chk((i < 8) ? "bp_s_ready" : "bp_full", s_ready, (i < 8) ? 1 : 0);
            chk("bp_hold", {m_valid, m_result}, {1'b1, 16'h3F80});
            step();
        end
        chk("bp_full_hold", {s_ready, m_valid, m_result}, {1'b0, 1'b1, 16'h3F80});
        chk("bp_no_en", en_q.size() - eb, 0);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        hb = cyc;
        chk("bp_idle_clr", {32'(dbg_m), 31'd0, mac_clr}, {32'(IDLE), 32'd1});
        for (int k = 0; k < 20 && !s_ready; k++) step();
        chk("bp_reopen", s_ready, 1);
        step();
        s_valid = 1'b0; s_last = 1'b0;
        chk("bp_reopen_cyc", cyc - hb, 3);
        wait_result("bp_b", 16'h4110, 9, 3, 0, v);

        // Randomized jobs against the arithmetic reference
        for (int j = 0; j < 16; j++) begin
            n = $urandom_range(1, 8);
            sum = 0;
            for (int i = 0; i < n; i++) begin
                x = $urandom_range(0, 4);
                y = $urandom_range(0, 4);
                sum += x * y;
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) step();
                push_pair(bf_enc(x), bf_enc(y), i == n - 1);
            end
            exp_q.push_back({bf_enc(sum), 8'(n), 2'((n > 3) ? 3 : n)});
            e = exp_q.pop_front();
            wait_result("rand", e[25:10], int'(e[9:2]), int'(e[1:0]), $urandom_range(0, 3), v);
        end

        chk("clr_en_exclusive", both_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
